// File: rtl/dmac_pkg.sv
// rtl/dmac_pkg.sv - shared state encoding and word size for the DMA engine
package dmac_pkg;

  localparam int WORD_BYTES = 4;

  typedef enum logic [2:0] {
    IDLE,
    RREQ,
    RDATA,
    WREQ,
    WRESP
  } state_t;

endpackage

// File: rtl/dmac_engine.sv
// rtl/dmac_engine.sv - single-word-at-a-time memory copy engine over AXI-like channels
module dmac_engine
  import dmac_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] src_addr_i,
  input  logic [ADDR_W-1:0] dst_addr_i,
  input  logic [15:0]       byte_len_i,
  input  logic              start_i,
  output logic              done_o,
  output logic [ADDR_W-1:0] araddr_o,
  output logic              arvalid_o,
  input  logic              arready_i,
  input  logic [31:0]       rdata_i,
  input  logic              rvalid_i,
  output logic              rready_o,
  output logic [ADDR_W-1:0] awaddr_o,
  output logic              awvalid_o,
  input  logic              awready_i,
  output logic [31:0]       wdata_o,
  output logic [3:0]        wstrb_o,
  output logic              wvalid_o,
  input  logic              wready_i,
  input  logic              bvalid_i,
  output logic              bready_o
);

  localparam logic [15:0] LEN_MASK = ~16'(WORD_BYTES - 1);

  state_t            state, state_next;
  logic [ADDR_W-1:0] src, dst;
  logic [15:0]       remaining;
  logic [31:0]       buffer;
  logic              aw_done, w_done;
  logic [15:0]       len_words;

  // Sub-word tail bytes are dropped; only whole words are copied.
  assign len_words = byte_len_i & LEN_MASK;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:  if (start_i && len_words != 16'd0) state_next = RREQ;
      RREQ:  if (arready_i) state_next = RDATA;
      RDATA: if (rvalid_i) state_next = WREQ;
      // Both handshakes are registered first, so WRESP follows one cycle later.
      WREQ:  if (aw_done && w_done) state_next = WRESP;
      WRESP: if (bvalid_i) state_next = (remaining == 16'(WORD_BYTES)) ? IDLE : RREQ;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      src       <= '0;
      dst       <= '0;
      remaining <= '0;
      buffer    <= '0;
      aw_done   <= 1'b0;
      w_done    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start_i && len_words != 16'd0) begin
            src       <= src_addr_i;
            dst       <= dst_addr_i;
            remaining <= len_words;
          end
        end
        RDATA: begin
          if (rvalid_i) buffer <= rdata_i;
        end
        WREQ: begin
          if (aw_done && w_done) begin
            aw_done <= 1'b0;
            w_done  <= 1'b0;
          end else begin
            if (awvalid_o && awready_i) aw_done <= 1'b1;
            if (wvalid_o && wready_i) w_done <= 1'b1;
          end
        end
        WRESP: begin
          if (bvalid_i) begin
            src       <= src + ADDR_W'(WORD_BYTES);
            dst       <= dst + ADDR_W'(WORD_BYTES);
            remaining <= remaining - 16'(WORD_BYTES);
          end
        end
        default: ;
      endcase
    end
  end

  assign done_o    = (state == IDLE);
  assign arvalid_o = (state == RREQ);
  assign araddr_o  = src;
  assign rready_o  = (state == RDATA);
  assign awvalid_o = (state == WREQ) && !aw_done;
  assign awaddr_o  = dst;
  assign wvalid_o  = (state == WREQ) && !w_done;
  assign wdata_o   = buffer;
  assign wstrb_o   = 4'hF;
  assign bready_o  = (state == WRESP);

endmodule
